// File: rtl/cabac_mvd_left_ctrl_pkg.sv
// Shared types and constants for the CABAC MVD left-neighbour sequencer.
// The optional CLR state is compiled in only when CABAC_MVD_CLR_EN is defined.
`ifndef FMV_WIDTH
`define FMV_WIDTH 8
`endif

package cabac_mvd_left_ctrl_pkg;

  localparam int MVD_W_P = `FMV_WIDTH + 1;

  // Context thresholds on |left| + |top|: below CTX_LO -> 0, above CTX_HI -> 2.
  localparam int unsigned CTX_LO = 3;
  localparam int unsigned CTX_HI = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CALC  = 3'd2,
    ST_WRITE = 3'd3
`ifdef CABAC_MVD_CLR_EN
    ,
    ST_CLR   = 3'd4
`endif
  } state_e;

endpackage

// File: rtl/cabac_mvd_left_ctrl_if.sv
// Request, context and left-memory signals of the MVD left-neighbour sequencer.
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
interface cabac_mvd_left_ctrl_if #(
  parameter int MVD_W = cabac_mvd_left_ctrl_pkg::MVD_W_P
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_row;
  logic               req_left_avail;
  logic [2*MVD_W-1:0] req_mvd;
  logic [2*MVD_W-1:0] req_top_mvd;
  logic               ctx_valid;
  logic [1:0]         ctx_x;
  logic [1:0]         ctx_y;
  logic               mem_r_en;
  logic [1:0]         mem_r_addr;
  logic [2*MVD_W-1:0] mem_r_data;
  logic               mem_w_en;
  logic [1:0]         mem_w_addr;
  logic [2*MVD_W-1:0] mem_w_data;
  logic [2:0]         dbg_state;

  modport slave (
    input  req_valid, req_row, req_left_avail, req_mvd, req_top_mvd, mem_r_data,
    output req_ready, ctx_valid, ctx_x, ctx_y, mem_r_en, mem_r_addr,
           mem_w_en, mem_w_addr, mem_w_data, dbg_state
  );

  modport master (
    output req_valid, req_row, req_left_avail, req_mvd, req_top_mvd, mem_r_data,
    input  req_ready, ctx_valid, ctx_x, ctx_y, mem_r_en, mem_r_addr,
           mem_w_en, mem_w_addr, mem_w_data, dbg_state
  );
endinterface

// File: rtl/cabac_mvd_left_ctrl_ctx_calc.sv
// Context increment for one MVD component from |left| + |top|.
// |-2^(MVD_W-1)| is representable in MVD_W unsigned bits, so the abs never wraps.
module cabac_mvd_ctx_calc
  import cabac_mvd_left_ctrl_pkg::*;
#(
  parameter int MVD_W = MVD_W_P
) (
  input  logic [MVD_W-1:0] left,
  input  logic [MVD_W-1:0] top,
  output logic [1:0]       ctx
);
  localparam logic [MVD_W:0] LO = (MVD_W+1)'(CTX_LO);
  localparam logic [MVD_W:0] HI = (MVD_W+1)'(CTX_HI);

  logic [MVD_W-1:0] abs_left;
  logic [MVD_W-1:0] abs_top;
  logic [MVD_W:0]   sum;

  assign abs_left = left[MVD_W-1] ? (~left + MVD_W'(1)) : left;
  assign abs_top  = top[MVD_W-1]  ? (~top + MVD_W'(1))  : top;
  assign sum      = {1'b0, abs_left} + {1'b0, abs_top};

  always_comb begin
    ctx = 2'd1;
    if (sum < LO)      ctx = 2'd0;
    else if (sum > HI) ctx = 2'd2;
  end
endmodule

// File: rtl/cabac_mvd_left_ctrl.sv
// Left-neighbour MVD sequencer: read left row, derive x/y contexts, write current MVD back.
// Define CABAC_MVD_CLR_EN to add the clr_i port and the four-row clear sequence.
module cabac_mvd_left_ctrl
  import cabac_mvd_left_ctrl_pkg::*;
#(
  parameter int MVD_W = MVD_W_P
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef CABAC_MVD_CLR_EN
  input  logic                  clr_i,
`endif
  cabac_mvd_left_ctrl_if.slave  bus
);
  state_e             state_q, state_d;
  logic [1:0]         row_q;
  logic               avail_q;
  logic [2*MVD_W-1:0] mvd_q;
  logic [2*MVD_W-1:0] top_q;
  logic [1:0]         ctx_x_q, ctx_y_q;
  logic [1:0]         ctx_x_d, ctx_y_d;
  logic [2*MVD_W-1:0] left;
  logic               clr_req;
  logic               accept;

`ifdef CABAC_MVD_CLR_EN
  logic [1:0] clr_row_q;
  assign clr_req = clr_i;
`else
  assign clr_req = 1'b0;
`endif

  // A pending clear takes priority over a simultaneous request.
  assign accept = (state_q == ST_IDLE) && bus.req_valid && !clr_req;
  assign left   = avail_q ? bus.mem_r_data : '0;

  cabac_mvd_ctx_calc #(.MVD_W(MVD_W)) u_ctx_x (
    .left (left[MVD_W-1:0]),
    .top  (top_q[MVD_W-1:0]),
    .ctx  (ctx_x_d)
  );

  cabac_mvd_ctx_calc #(.MVD_W(MVD_W)) u_ctx_y (
    .left (left[2*MVD_W-1:MVD_W]),
    .top  (top_q[2*MVD_W-1:MVD_W]),
    .ctx  (ctx_y_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      avail_q <= 1'b0;
      mvd_q   <= '0;
      top_q   <= '0;
      ctx_x_q <= '0;
      ctx_y_q <= '0;
`ifdef CABAC_MVD_CLR_EN
      clr_row_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        row_q   <= bus.req_row;
        avail_q <= bus.req_left_avail;
        mvd_q   <= bus.req_mvd;
        top_q   <= bus.req_top_mvd;
      end
      if (state_q == ST_CALC) begin
        ctx_x_q <= ctx_x_d;
        ctx_y_q <= ctx_y_d;
      end
`ifdef CABAC_MVD_CLR_EN
      clr_row_q <= (state_q == ST_CLR) ? clr_row_q + 2'd1 : 2'd0;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
`ifdef CABAC_MVD_CLR_EN
        if (clr_req) state_d = ST_CLR;
        else
`endif
        if (bus.req_valid) state_d = ST_READ;
      end
      ST_READ:  state_d = ST_CALC;
      ST_CALC:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
`ifdef CABAC_MVD_CLR_EN
      ST_CLR:   if (clr_row_q == 2'd3) state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  // Read and write strobes live in different states, so a row is never read and written together.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.ctx_valid  = 1'b0;
    bus.mem_r_en   = 1'b0;
    bus.mem_r_addr = '0;
    bus.mem_w_en   = 1'b0;
    bus.mem_w_addr = '0;
    bus.mem_w_data = '0;
    case (state_q)
      ST_IDLE: bus.req_ready = !clr_req;
      ST_READ: begin
        bus.mem_r_en   = 1'b1;
        bus.mem_r_addr = row_q;
      end
      ST_WRITE: begin
        bus.ctx_valid  = 1'b1;
        bus.mem_w_en   = 1'b1;
        bus.mem_w_addr = row_q;
        bus.mem_w_data = mvd_q;
      end
`ifdef CABAC_MVD_CLR_EN
      ST_CLR: begin
        bus.mem_w_en   = 1'b1;
        bus.mem_w_addr = clr_row_q;
      end
`endif
      default: ;
    endcase
  end

  assign bus.ctx_x     = ctx_x_q;
  assign bus.ctx_y     = ctx_y_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_cabac_mvd_left_ctrl.sv
// Bench for cabac_mvd_left_ctrl: directed vector table, reset/clear sequences, random requests.
// Build with CABAC_MVD_CLR_EN defined to exercise the clear sequence as well.
module tb_cabac_mvd_left_ctrl;
  localparam int W = 9;

  logic clk;
  logic rst;
`ifdef CABAC_MVD_CLR_EN
  logic clr_i;
`endif

  cabac_mvd_left_ctrl_if #(.MVD_W(W)) bus();

  cabac_mvd_left_ctrl #(.MVD_W(W)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef CABAC_MVD_CLR_EN
    .clr_i (clr_i),
`endif
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 18x4 register file model with registered read ----------------
  logic [2*W-1:0] mem [4];
  logic           pre_en;
  logic [1:0]     pre_addr;
  logic [2*W-1:0] pre_data;

  always @(posedge clk) begin
    if (bus.mem_r_en) bus.mem_r_data <= mem[bus.mem_r_addr];
    if (bus.mem_w_en) mem[bus.mem_w_addr] <= bus.mem_w_data;
    if (pre_en)       mem[pre_addr] <= pre_data;
  end

  // ---------------- reference model ----------------
  int ref_y [4];
  int ref_x [4];
  int n_checks;
  int n_fail;

  function automatic logic [2*W-1:0] pack(input int y, input int x);
    logic [31:0] yy, xx;
    yy = y;
    xx = x;
    return {yy[W-1:0], xx[W-1:0]};
  endfunction

  function automatic int ctx_of(input int l, input int t);
    int s;
    s = (l < 0 ? -l : l) + (t < 0 ? -t : t);
    if (s < 3) return 0;
    if (s > 32) return 2;
    return 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input int row, input int y, input int x);
    @(negedge clk);
    pre_en = 1'b1;
    pre_addr = 2'(row);
    pre_data = pack(y, x);
    ref_y[row] = y;
    ref_x[row] = x;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Called at a negedge; leaves at the negedge of cycle T+4.
  task automatic do_req(input string tag, input int row, input int av,
                        input int my, input int mx, input int ty, input int tx,
                        input int ex, input int ey);
    int waited;
    waited = 0;
    while (!bus.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, " ready_wait"}, int'(bus.req_ready), 1);
    bus.req_valid      = 1'b1;
    bus.req_row        = 2'(row);
    bus.req_left_avail = av[0];
    bus.req_mvd        = pack(my, mx);
    bus.req_top_mvd    = pack(ty, tx);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk({tag, " r_en@T+1"}, int'(bus.mem_r_en), 1);
    chk({tag, " r_addr@T+1"}, int'(bus.mem_r_addr), row);
    chk({tag, " ready@T+1"}, int'(bus.req_ready), 0);
    @(negedge clk);
    chk({tag, " ctx_valid@T+2"}, int'(bus.ctx_valid), 0);
    chk({tag, " w_en@T+2"}, int'(bus.mem_w_en), 0);
    @(negedge clk);
    chk({tag, " ctx_valid@T+3"}, int'(bus.ctx_valid), 1);
    chk({tag, " w_en@T+3"}, int'(bus.mem_w_en), 1);
    chk({tag, " r_en@T+3"}, int'(bus.mem_r_en), 0);
    chk({tag, " w_addr"}, int'(bus.mem_w_addr), row);
    chk({tag, " w_data"}, int'(bus.mem_w_data), int'(pack(my, mx)));
    chk({tag, " ctx_x"}, int'(bus.ctx_x), ex);
    chk({tag, " ctx_y"}, int'(bus.ctx_y), ey);
    @(negedge clk);
    chk({tag, " ready@T+4"}, int'(bus.req_ready), 1);
    chk({tag, " ctx_valid@T+4"}, int'(bus.ctx_valid), 0);
    chk({tag, " ctx_x_hold"}, int'(bus.ctx_x), ex);
    chk({tag, " ctx_y_hold"}, int'(bus.ctx_y), ey);
    ref_y[row] = my;
    ref_x[row] = mx;
  endtask

  task automatic model_req(input string tag, input int row, input int av,
                           input int my, input int mx, input int ty, input int tx);
    int ly, lx;
    ly = av ? ref_y[row] : 0;
    lx = av ? ref_x[row] : 0;
    do_req(tag, row, av, my, mx, ty, tx, ctx_of(lx, tx), ctx_of(ly, ty));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit pre;
    int pre_y, pre_x;
    int row, av;
    int my, mx, ty, tx;
    int ex, ey;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1, 0, 0,      1, 1, 5, -3, 0, 2,     0, 0};
    vecs[1] = '{1, 0, 0,      2, 1, -20, 40, 0, 0,   0, 0};
    vecs[2] = '{0, 0, 0,      2, 1, 7, 7, 0, 0,      2, 1};
    vecs[3] = '{1, 100, 100,  3, 0, 1, 1, 1, 1,      0, 0};
    vecs[4] = '{1, 0, 0,      0, 1, 0, -256, 0, 0,   0, 0};
    vecs[5] = '{0, 0, 0,      0, 1, 3, 3, 0, 0,      2, 0};
    vecs[6] = '{0, 0, 0,      1, 1, 0, 33, 27, 0,    1, 1};
    vecs[7] = '{0, 0, 0,      1, 1, 0, 0, 0, 0,      2, 0};
    vecs[8] = '{0, 0, 0,      3, 1, -256, 255, -2, -1, 0, 1};
    vecs[9] = '{0, 0, 0,      3, 1, 0, 0, 0, 0,      2, 2};

    n_checks = 0;
    n_fail = 0;
    pre_en = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    bus.req_valid = 1'b0;
    bus.req_row = '0;
    bus.req_left_avail = 1'b0;
    bus.req_mvd = '0;
    bus.req_top_mvd = '0;
`ifdef CABAC_MVD_CLR_EN
    clr_i = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      ref_y[i] = 0;
      ref_x[i] = 0;
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst req_ready", int'(bus.req_ready), 1);
    chk("rst ctx_valid", int'(bus.ctx_valid), 0);
    chk("rst ctx_x", int'(bus.ctx_x), 0);
    chk("rst ctx_y", int'(bus.ctx_y), 0);
    chk("rst r_en", int'(bus.mem_r_en), 0);
    chk("rst r_addr", int'(bus.mem_r_addr), 0);
    chk("rst w_en", int'(bus.mem_w_en), 0);
    chk("rst w_addr", int'(bus.mem_w_addr), 0);
    chk("rst w_data", int'(bus.mem_w_data), 0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].pre) preload(vecs[i].row, vecs[i].pre_y, vecs[i].pre_x);
      do_req($sformatf("vec%0d", i), vecs[i].row, vecs[i].av, vecs[i].my, vecs[i].mx,
             vecs[i].ty, vecs[i].tx, vecs[i].ex, vecs[i].ey);
    end

    // Reset while the request sits in CALC: nothing written, request dropped.
    bus.req_valid      = 1'b1;
    bus.req_row        = 2'd2;
    bus.req_left_avail = 1'b1;
    bus.req_mvd        = pack(-200, 150);
    bus.req_top_mvd    = pack(50, 50);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("midrst r_en", int'(bus.mem_r_en), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst w_en", int'(bus.mem_w_en), 0);
    chk("midrst ctx_valid", int'(bus.ctx_valid), 0);
    chk("midrst ctx_x", int'(bus.ctx_x), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst ready", int'(bus.req_ready), 1);
    chk("midrst w_en_after", int'(bus.mem_w_en), 0);
    model_req("after_rst", 2, 1, 1, 1, 0, 0);

`ifdef CABAC_MVD_CLR_EN
    preload(0, 77, -77);
    preload(1, 40, 40);
    @(negedge clk);
    clr_i = 1'b1;
    bus.req_valid      = 1'b1;
    bus.req_row        = 2'd1;
    bus.req_left_avail = 1'b1;
    bus.req_mvd        = pack(9, 9);
    bus.req_top_mvd    = pack(0, 5);
    @(negedge clk);
    chk("clr ready_low", int'(bus.req_ready), 0);
    clr_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("clr%0d w_en", i), int'(bus.mem_w_en), 1);
      chk($sformatf("clr%0d w_addr", i), int'(bus.mem_w_addr), i);
      chk($sformatf("clr%0d w_data", i), int'(bus.mem_w_data), 0);
      chk($sformatf("clr%0d ready", i), int'(bus.req_ready), 0);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      ref_y[i] = 0;
      ref_x[i] = 0;
    end
    do_req("clr_req", 1, 1, 9, 9, 0, 5, 1, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      int r, av, my, mx, ty, tx;
      r  = int'($urandom_range(0, 3));
      av = int'($urandom_range(0, 1));
      my = int'($urandom_range(0, 511)) - 256;
      mx = int'($urandom_range(0, 511)) - 256;
      ty = int'($urandom_range(0, 40)) - 20;
      tx = int'($urandom_range(0, 511)) - 256;
      if (i % 3 == 0) tx = int'($urandom_range(0, 6)) - 3;
      model_req($sformatf("rnd%0d", i), r, av, my, mx, ty, tx);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
